// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU command scheduler.
package alu_sched_pkg;

  typedef enum logic [2:0] {IDLE, SEND_OP, SEND_ARG, WAIT, RESP} state_t;

  localparam int ARG_BYTES   = 4;
  localparam int TIMEOUT_DEF = 64;

  // Operand bytes leave most-significant first.
  function automatic logic [7:0] arg_byte(input logic [31:0] arg, input logic [1:0] idx);
    case (idx)
      2'd0:    return arg[31:24];
      2'd1:    return arg[23:16];
      2'd2:    return arg[15:8];
      default: return arg[7:0];
    endcase
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Requester and ALU-side signal bundle of the scheduler.
interface alu_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_val;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [NUM_REQ*8-1:0]  req_op;
  logic [NUM_REQ*32-1:0] req_arg;
  logic [NUM_REQ-1:0]    rsp_val;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  alu_ctl;
  logic [7:0]            alu_dat;
  logic                  alu_ready;
  logic [31:0]           alu_result;

  modport slave (
    input  req_val, req_op, req_arg, alu_ready, alu_result,
    output req_rdy, rsp_val, rsp_data, rsp_err, alu_ctl, alu_dat
  );

  modport master (
    output req_val, req_op, req_arg, alu_ready, alu_result,
    input  req_rdy, rsp_val, rsp_data, rsp_err, alu_ctl, alu_dat
  );
endinterface

// File: rtl/alu_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority moves past the last grantee on adv.
module rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx;

  // Scan from the farthest slot down so the nearest requester after ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Arbitrates requesters onto a byte-serial ALU: opcode, 4 operand bytes, wait, respond.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic        clk,
  input logic        rst,
  alu_sched_if.slave bus
);
  state_t             state;
  logic [1:0]         byte_cnt;
  logic [7:0]         wait_cnt;
  logic [NUM_REQ-1:0] owner;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_val_q;
  logic [7:0]         sel_op;
  logic [7:0]         alu_dat_q;
  logic [31:0]        sel_arg;
  logic [31:0]        arg_q;
  logic [31:0]        rsp_data_q;
  logic               alu_ctl_q;
  logic               rsp_err_q;
  logic               grant_fire;

  assign grant_fire = (state == IDLE) && bus.alu_ready && (|bus.req_val) && !rst;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req_val),
    .adv (grant_fire),
    .gnt (gnt)
  );

  always_comb begin
    sel_op  = '0;
    sel_arg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op  = bus.req_op[8*i +: 8];
        sel_arg = bus.req_arg[32*i +: 32];
      end
    end
  end

  // Operand capture at grant; the opcode is captured straight into alu_dat.
  always_ff @(posedge clk) begin
    if (grant_fire) arg_q <= sel_arg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      wait_cnt   <= '0;
      owner      <= '0;
      alu_ctl_q  <= 1'b0;
      alu_dat_q  <= '0;
      rsp_val_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_val_q <= '0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            owner     <= gnt;
            alu_ctl_q <= 1'b1;
            alu_dat_q <= sel_op;
            state     <= SEND_OP;
          end
        end
        SEND_OP: begin
          alu_ctl_q <= 1'b0;
          alu_dat_q <= arg_byte(arg_q, 2'd0);
          byte_cnt  <= '0;
          state     <= SEND_ARG;
        end
        SEND_ARG: begin
          if (byte_cnt == 2'(ARG_BYTES - 1)) begin
            alu_dat_q <= '0;
            wait_cnt  <= '0;
            state     <= WAIT;
          end else begin
            alu_dat_q <= arg_byte(arg_q, byte_cnt + 2'd1);
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        WAIT: begin
          // The ALU still shows its idle flag in the first cycle, so it is not trusted yet.
          if ((wait_cnt != 8'd0) && bus.alu_ready) begin
            rsp_data_q <= bus.alu_result;
            rsp_err_q  <= 1'b0;
            rsp_val_q  <= owner;
            state      <= RESP;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            rsp_val_q  <= owner;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_rdy  = grant_fire ? gnt : '0;
  assign bus.rsp_val  = rsp_val_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.alu_ctl  = alu_ctl_q;
  assign bus.alu_dat  = alu_dat_q;

endmodule
